reg_bank: RTL and testbench

Parametrised bank of `NUM_REGS` general-purpose registers, each `WIDTH` bits, sharing one tristate data bus. It is the multi-register successor to the single 8-bit bus register in the CPU datapath. On top of plain bus load and bus drive, it adds increment, decrement and register-to-register move operations, sequenced by a small FSM with a `busy` handshake. All register contents are exposed on a flat debug/display output.

---
 rtl/reg_bank_pkg.sv | 16 +
 rtl/reg_bank_if.sv | 32 +++
 rtl/reg_cell.sv | 18 +
 rtl/reg_bank.sv | 117 +++++++++++
 tb/tb_reg_bank.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared encodings for the register bank: operation codes and FSM states.
package reg_bank_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    MV_RD = 2'd2,
    MV_WR = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bank_if.sv
// Control/status bundle of the register bank. The data bus itself stays a
// plain inout on the top so the tristate resolves on an ordinary net.
interface reg_bank_if #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic                      wr_en;
  logic [SEL_W-1:0]          wr_sel;
  logic                      rd_en;
  logic [SEL_W-1:0]          rd_sel;
  logic                      op_start;
  logic [1:0]                op;
  logic [SEL_W-1:0]          op_dst;
  logic [SEL_W-1:0]          op_src;
  logic                      busy;
  logic                      carry;
  logic                      zero;
  logic [NUM_REGS*WIDTH-1:0] mem_out;

  modport master (
    output wr_en, wr_sel, rd_en, rd_sel, op_start, op, op_dst, op_src,
    input  busy, carry, zero, mem_out
  );

  modport slave (
    input  wr_en, wr_sel, rd_en, rd_sel, op_start, op, op_dst, op_src,
    output busy, carry, zero, mem_out
  );

endinterface

// File: rtl/reg_cell.sv
// Single WIDTH-bit register with async clear and a load enable.
module reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // hold unless loaded; clear wins over everything
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)  q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/reg_bank.sv
// Bank of NUM_REGS registers on a shared tristate bus, with an FSM that
// sequences INC/DEC (one execute cycle) and MOVE (read then write cycle).
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             clr_n,
  reg_bank_if.slave        rb,
  inout  wire  [WIDTH-1:0] bus
);

  state_t                         state_q, state_d;
  logic [1:0]                     op_q;
  logic [SEL_W-1:0]               dst_q, src_q;
  logic [WIDTH-1:0]               tmp_q;
  logic                           carry_q, zero_q, busy_q;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs_d;
  logic [NUM_REGS-1:0]            ld;
  logic                           accept, fsm_we, is_inc;
  logic [WIDTH-1:0]               cur, fsm_res;

  assign accept  = (state_q == IDLE) && rb.op_start;
  assign is_inc  = (op_q == OP_INC);
  assign cur     = regs_q[dst_q];
  assign fsm_we  = (state_q == EXEC) || (state_q == MV_WR);
  assign fsm_res = (state_q == MV_WR) ? tmp_q
                 : (is_inc ? cur + 1'b1 : cur - 1'b1);

  // next-state: NOP is accepted but never leaves IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rb.op_start) begin
          if (rb.op == OP_MOV)      state_d = MV_RD;
          else if (rb.op != OP_NOP) state_d = EXEC;
        end
      end
      EXEC:    state_d = IDLE;
      MV_RD:   state_d = MV_WR;
      MV_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register; busy is registered from next-state so it is glitch-free
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // operands frozen at acceptance so later input changes are ignored
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q  <= OP_NOP;
      dst_q <= '0;
      src_q <= '0;
    end else if (accept) begin
      op_q  <= rb.op;
      dst_q <= rb.op_dst;
      src_q <= rb.op_src;
    end
  end

  // MOVE staging: source sampled one edge after acceptance
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                 tmp_q <= '0;
    else if (state_q == MV_RD)  tmp_q <= regs_q[src_q];
  end

  // flags follow INC/DEC even when a bus write steals the destination
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      carry_q <= is_inc ? (cur == '1) : (cur == '0);
      zero_q  <= (fsm_res == '0);
    end
  end

  // per-register load mux: bus write has priority over the FSM result
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    logic bus_hit, fsm_hit;
    assign bus_hit   = rb.wr_en && (rb.wr_sel == SEL_W'(i));
    assign fsm_hit   = fsm_we && (dst_q == SEL_W'(i));
    assign ld[i]     = bus_hit | fsm_hit;
    assign regs_d[i] = bus_hit ? bus : fsm_res;

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .clr_n(clr_n),
      .ld   (ld[i]),
      .d    (regs_d[i]),
      .q    (regs_q[i])
    );
  end

  // drive only for a pure read; released during clear and during loads
  assign bus = (rb.rd_en && !rb.wr_en && clr_n) ? regs_q[rb.rd_sel] : 'z;

  assign rb.busy    = busy_q;
  assign rb.carry   = carry_q;
  assign rb.zero    = zero_q;
  assign rb.mem_out = regs_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (WIDTH=8, NUM_REGS=4): vector tables,
// directed multi-cycle corner cases, then random traffic against a model.
module tb_reg_bank;
  import reg_bank_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  wire  [W-1:0] bus;
  logic         tb_drv = 1'b0;
  logic [W-1:0] tb_val = '0;

  assign bus = tb_drv ? tb_val : 'z;

  reg_bank_if #(.WIDTH(W), .NUM_REGS(N)) rb ();

  reg_bank #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .rb   (rb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state: register values and flags
  logic [7:0] m [4];
  logic       mc, mz;

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  wdata;
    logic [31:0] exp_mem;
  } ld_vec_t;

  typedef struct {
    logic [1:0] op;
    logic [1:0] dst;
    logic [7:0] init;
    logic [7:0] exp_val;
    logic       exp_c;
    logic       exp_z;
  } op_vec_t;

  ld_vec_t ld_tab [4];
  op_vec_t op_tab [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] reg_of(input int s);
    return rb.mem_out[8*s +: 8];
  endfunction

  function automatic logic [31:0] model_mem();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  task automatic bus_write(input logic [1:0] s, input logic [7:0] v);
    rb.wr_en = 1'b1; rb.wr_sel = s; tb_drv = 1'b1; tb_val = v;
    tick();
    rb.wr_en = 1'b0; tb_drv = 1'b0;
  endtask

  // issue one op, scramble the operand inputs afterwards, count busy edges
  task automatic run_op(input logic [1:0] o, input logic [1:0] d,
                        input logic [1:0] s, output int lat);
    rb.op_start = 1'b1; rb.op = o; rb.op_dst = d; rb.op_src = s;
    tick();
    rb.op_start = 1'b0; rb.op = ~o; rb.op_dst = ~d; rb.op_src = ~s;
    lat = 0;
    while (rb.busy && lat < 6) begin
      tick();
      lat++;
    end
  endtask

  // behavioural effect of an op on the reference state
  task automatic model_op(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s);
    int r;
    r = int'(m[d]);
    case (o)
      OP_INC: begin m[d] = 8'((r + 1) % 256);   mc = (r == 255); mz = (m[d] == 0); end
      OP_DEC: begin m[d] = 8'((r + 255) % 256); mc = (r == 0);   mz = (m[d] == 0); end
      OP_MOV: m[d] = m[s];
      default: ;
    endcase
  endtask

  function automatic int model_lat(input logic [1:0] o);
    case (o)
      OP_INC, OP_DEC: return 1;
      OP_MOV:         return 2;
      default:        return 0;
    endcase
  endfunction

  initial begin
    int          lat, kind;
    logic [1:0]  s, d, o;
    logic [7:0]  v;

    ld_tab[0] = '{2'd2, 8'hCF, 32'h00CF_0000};
    ld_tab[1] = '{2'd0, 8'h11, 32'h00CF_0011};
    ld_tab[2] = '{2'd3, 8'hA5, 32'hA5CF_0011};
    ld_tab[3] = '{2'd1, 8'hFF, 32'hA5CF_FF11};

    op_tab[0] = '{OP_INC, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0};
    op_tab[1] = '{OP_INC, 2'd1, 8'hFF, 8'h00, 1'b1, 1'b1};
    op_tab[2] = '{OP_DEC, 2'd2, 8'h01, 8'h00, 1'b0, 1'b1};
    op_tab[3] = '{OP_DEC, 2'd3, 8'h00, 8'hFF, 1'b1, 1'b0};
    op_tab[4] = '{OP_INC, 2'd2, 8'h7F, 8'h80, 1'b0, 1'b0};
    op_tab[5] = '{OP_DEC, 2'd1, 8'h80, 8'h7F, 1'b0, 1'b0};

    rb.wr_en = 0; rb.wr_sel = 0; rb.rd_en = 0; rb.rd_sel = 0;
    rb.op_start = 0; rb.op = OP_NOP; rb.op_dst = 0; rb.op_src = 0;

    // reset state
    #12;
    chk("rst_mem", rb.mem_out, 32'h0);
    chk("rst_busy", 32'(rb.busy), 32'h0);
    chk("rst_carry", 32'(rb.carry), 32'h0);
    chk("rst_zero", 32'(rb.zero), 32'h0);
    clr_n = 1'b1;
    tick();

    // load table with read-back over the bus
    foreach (ld_tab[i]) begin
      bus_write(ld_tab[i].sel, ld_tab[i].wdata);
      chk("load_mem", rb.mem_out, ld_tab[i].exp_mem);
      rb.rd_en = 1'b1; rb.rd_sel = ld_tab[i].sel;
      #1;
      chk("load_rdbus", 32'(bus), 32'(ld_tab[i].wdata));
      rb.rd_en = 1'b0;
    end

    // read and write together: external value wins, block stays off the bus
    rb.rd_en = 1'b1; rb.rd_sel = 2'd2; rb.wr_en = 1'b1; rb.wr_sel = 2'd2;
    tb_drv = 1'b1; tb_val = 8'h8C;
    #1;
    chk("rdwr_bus", 32'(bus), 32'h8C);
    tick();
    rb.wr_en = 1'b0; rb.rd_en = 1'b0; tb_drv = 1'b0;
    chk("rdwr_reg2", 32'(reg_of(2)), 32'h8C);

    // released bus: an external 00 must read back unchanged
    rb.rd_sel = 2'd2; tb_drv = 1'b1; tb_val = 8'h00;
    #1;
    chk("release_bus", 32'(bus), 32'h00);
    tb_drv = 1'b0;

    // INC/DEC flag boundaries
    foreach (op_tab[i]) begin
      bus_write(op_tab[i].dst, op_tab[i].init);
      run_op(op_tab[i].op, op_tab[i].dst, 2'd0, lat);
      chk("op_lat", 32'(lat), 32'd1);
      chk("op_val", 32'(reg_of(int'(op_tab[i].dst))), 32'(op_tab[i].exp_val));
      chk("op_carry", 32'(rb.carry), 32'(op_tab[i].exp_c));
      chk("op_zero", 32'(rb.zero), 32'(op_tab[i].exp_z));
    end

    // DEC borrow with op_start held through busy: exactly one decrement
    bus_write(2'd3, 8'h00);
    rb.op_start = 1'b1; rb.op = OP_DEC; rb.op_dst = 2'd3;
    tick();
    chk("dec_busy1", 32'(rb.busy), 32'h1);
    tick();
    rb.op_start = 1'b0;
    chk("dec_busy0", 32'(rb.busy), 32'h0);
    chk("dec_val", 32'(reg_of(3)), 32'hFF);
    chk("dec_flags", {30'd0, rb.carry, rb.zero}, 32'h2);
    tick();
    chk("dec_once", 32'(reg_of(3)), 32'hFF);
    chk("dec_idle", 32'(rb.busy), 32'h0);

    // MOVE 0 -> 3, busy exactly two cycles, flags untouched
    bus_write(2'd0, 8'h5A);
    rb.op_start = 1'b1; rb.op = OP_MOV; rb.op_src = 2'd0; rb.op_dst = 2'd3;
    tick();
    rb.op_start = 1'b0;
    chk("mv_busy_a", 32'(rb.busy), 32'h1);
    tick();
    chk("mv_busy_b", 32'(rb.busy), 32'h1);
    chk("mv_early", 32'(reg_of(3)), 32'hFF);
    tick();
    chk("mv_busy_c", 32'(rb.busy), 32'h0);
    chk("mv_dst", 32'(reg_of(3)), 32'h5A);
    chk("mv_src", 32'(reg_of(0)), 32'h5A);
    chk("mv_flags", {30'd0, rb.carry, rb.zero}, 32'h2);

    // MOVE source sees a bus write landing on the accept edge; dst latched
    rb.op_start = 1'b1; rb.op = OP_MOV; rb.op_src = 2'd2; rb.op_dst = 2'd1;
    rb.wr_en = 1'b1; rb.wr_sel = 2'd2; tb_drv = 1'b1; tb_val = 8'h3C;
    tick();
    rb.op_start = 1'b0; rb.wr_en = 1'b0; tb_drv = 1'b0; rb.op_dst = 2'd0;
    tick();
    tick();
    chk("mvcap_dst", 32'(reg_of(1)), 32'h3C);
    chk("mvcap_keep0", 32'(reg_of(0)), 32'h5A);

    // collision: bus write to the INC target on the commit edge wins
    bus_write(2'd1, 8'hFF);
    rb.op_start = 1'b1; rb.op = OP_INC; rb.op_dst = 2'd1;
    tick();
    rb.op_start = 1'b0;
    rb.wr_en = 1'b1; rb.wr_sel = 2'd1; tb_drv = 1'b1; tb_val = 8'h77;
    tick();
    rb.wr_en = 1'b0; tb_drv = 1'b0;
    chk("coll_val", 32'(reg_of(1)), 32'h77);
    chk("coll_flags", {30'd0, rb.carry, rb.zero}, 32'h3);

    // reset while in MV_RD with rd_en high: everything cleared, no late write
    rb.op_start = 1'b1; rb.op = OP_MOV; rb.op_src = 2'd0; rb.op_dst = 2'd2;
    tick();
    rb.op_start = 1'b0; rb.rd_en = 1'b1; rb.rd_sel = 2'd0;
    clr_n = 1'b0;
    #1;
    chk("midrst_mem", rb.mem_out, 32'h0);
    chk("midrst_busy", 32'(rb.busy), 32'h0);
    chk("midrst_flags", {30'd0, rb.carry, rb.zero}, 32'h0);
    tick();
    clr_n = 1'b1;
    tick();
    tick();
    rb.rd_en = 1'b0;
    chk("postrst_mem", rb.mem_out, 32'h0);
    chk("postrst_busy", 32'(rb.busy), 32'h0);

    // random traffic against the reference model
    foreach (m[i]) m[i] = 8'h00;
    mc = 1'b0; mz = 1'b0;
    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom_range(0, 3));
      s = 2'($urandom);
      d = 2'($urandom);
      v = 8'($urandom);
      o = 2'($urandom);
      case (kind)
        0: begin
          bus_write(s, v);
          m[s] = v;
          chk("rnd_wr", rb.mem_out, model_mem());
        end
        1: begin
          rb.rd_en = 1'b1; rb.rd_sel = s;
          #1;
          chk("rnd_rd", 32'(bus), 32'(m[s]));
          rb.rd_en = 1'b0;
        end
        default: begin
          if (kind == 2 && v[0]) bus_write(d, v[0] ? 8'hFF : 8'h00);
          if (kind == 2 && v[0]) m[d] = 8'hFF;
          run_op(o, d, s, lat);
          model_op(o, d, s);
          chk("rnd_lat", 32'(lat), 32'(model_lat(o)));
          chk("rnd_mem", rb.mem_out, model_mem());
          chk("rnd_flags", {30'd0, rb.carry, rb.zero}, {30'd0, mc, mz});
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
